// File: rtl/onehot_decode_seq_pkg.sv
// Shared types and helpers for the sequential 2-to-4 one-hot decoder.
// Holds the control-state encoding and the one-hot mapping used by the decoder.
package onehot_decode_seq_pkg;

  // The timer counts down from at most 255.
  localparam int unsigned TimerW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    logic [3:0] res;
    res = 4'b0001 << code;
    return res;
  endfunction

endpackage

// File: rtl/onehot_decode_comb.sv
// Purely combinational 2-bit to 4-bit one-hot decoder.
// Also usable by the gate-level top.
module onehot_decode_comb
  import onehot_decode_seq_pkg::*;
(
  input  logic [1:0] code,
  output logic [3:0] onehot
);

  assign onehot = onehot4(code);

endmodule

// File: rtl/onehot_decode_seq.sv
// Sequential 2-to-4 decoder: accepts a code per handshake, holds its one-hot word for
// HOLD_CYCLES, inserts GAP_CYCLES of zero output and counts accepted symbols.
module onehot_decode_seq
  import onehot_decode_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_code,
  output logic             in_ready,
  input  logic             abort,
  output logic [3:0]       g,
  output logic             g_valid,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count
);

  localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLoad  =
      (GAP_CYCLES == 0) ? '0 : TimerW'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        g_q, g_d;
  logic              g_valid_q, g_valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dec_word;

  onehot_decode_comb u_dec (
    .code   (in_code),
    .onehot (dec_word)
  );

  assign in_ready = (state_q == StIdle) && !abort;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    g_d       = g_q;
    g_valid_d = g_valid_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    if (abort) begin
      // Abort drops the symbol in flight but keeps it counted.
      state_d   = StIdle;
      timer_d   = '0;
      g_d       = '0;
      g_valid_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_d   = StDrive;
            timer_d   = HoldLoad;
            g_d       = dec_word;
            g_valid_d = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        StDrive: begin
          if (timer_q == '0) begin
            g_d       = '0;
            g_valid_d = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_d = StGap;
              timer_d = GapLoad;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        StGap: begin
          if (timer_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        default: begin
          state_d   = StIdle;
          timer_d   = '0;
          g_d       = '0;
          g_valid_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      g_q       <= '0;
      g_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      g_q       <= g_d;
      g_valid_q <= g_valid_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign g         = g_q;
  assign g_valid   = g_valid_q;
  assign busy      = busy_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_onehot_decode_seq.sv
// Scoreboard bench for onehot_decode_seq: three configurations share one stimulus stream,
// each compared against a cycle-timeline reference model.
module tb_onehot_decode_seq;

  localparam int N = 3;
  localparam int HoldP[N] = '{4, 4, 3};
  localparam int GapP[N]  = '{1, 0, 2};
  localparam int CntWP[N] = '{8, 8, 2};

  typedef struct {
    logic [3:0] g;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] in_code = 2'd0;

  logic [3:0] g_w[N];
  logic       gv_w[N];
  logic       busy_w[N];
  logic       rdy_w[N];
  logic [7:0] cnt_w[N];
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;
  int epoch = 0;

  // Reference model: per DUT, edges elapsed since the accepting edge.
  bit         m_active[N];
  int         m_el[N];
  int         m_cnt[N];
  logic [3:0] m_g[N];
  exp_t       q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  onehot_decode_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_ready(rdy_w[0]),
    .abort(abort), .g(g_w[0]), .g_valid(gv_w[0]), .busy(busy_w[0]), .sym_count(cnt_a)
  );
  onehot_decode_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_ready(rdy_w[1]),
    .abort(abort), .g(g_w[1]), .g_valid(gv_w[1]), .busy(busy_w[1]), .sym_count(cnt_b)
  );
  onehot_decode_seq #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_ready(rdy_w[2]),
    .abort(abort), .g(g_w[2]), .g_valid(gv_w[2]), .busy(busy_w[2]), .sym_count(cnt_c)
  );

  assign cnt_w[0] = cnt_a;
  assign cnt_w[1] = cnt_b;
  assign cnt_w[2] = {6'b0, cnt_c};

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // 0 = idle, 1 = driving, 2 = gap, as seen after the most recent edge.
  function automatic int phase(input int i);
    if (!m_active[i]) return 0;
    if (m_el[i] < HoldP[i]) return 1;
    if (m_el[i] < HoldP[i] + GapP[i]) return 2;
    return 0;
  endfunction

  task automatic sb_push(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_pop(input int i, output exp_t e);
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // One clock cycle of stimulus; the model advances to the state after the coming edge.
  task automatic step(input logic v, input logic [1:0] c, input logic ab);
    bit idle;
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    abort    = ab;
    #1;
    for (int i = 0; i < N; i++) begin
      idle = (phase(i) == 0);
      chk("in_ready", i, 32'(rdy_w[i]), 32'(idle && !ab));
      if (ab) begin
        m_active[i] = 1'b0;
      end else if (idle && v) begin
        m_active[i] = 1'b1;
        m_el[i]     = 0;
        m_cnt[i]    = (m_cnt[i] + 1) % (1 << CntWP[i]);
        m_g[i]      = 4'b0001 << c;
        sb_push(i, '{g: m_g[i], cnt: m_cnt[i]});
      end else if (m_active[i]) begin
        m_el[i]++;
        if (phase(i) == 0) m_active[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_g", i, 32'(g_w[i]), 32'd0);
      chk("rst_g_valid", i, 32'(gv_w[i]), 32'd0);
      chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("rst_sym_count", i, 32'(cnt_w[i]), 32'd0);
      m_active[i] = 1'b0;
      m_el[i]     = 0;
      m_cnt[i]    = 0;
      m_g[i]      = 4'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
    epoch++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (phase(i) != 0 && n < 600) begin
      step(1'b0, 2'd0, 1'b0);
      n++;
    end
    if (n >= 600) chk("idle_timeout", i, 32'd1, 32'd0);
  endtask

  // Monitor: per-cycle model comparison plus scoreboard pop on each new symbol.
  initial begin
    bit   prev[N];
    int   seen_epoch;
    int   ph;
    exp_t e;
    seen_epoch = 0;
    for (int i = 0; i < N; i++) prev[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (seen_epoch != epoch) begin
        seen_epoch = epoch;
        for (int i = 0; i < N; i++) prev[i] = 1'b0;
      end
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          ph = phase(i);
          chk("g", i, 32'(g_w[i]), 32'((ph == 1) ? m_g[i] : 4'b0));
          chk("g_valid", i, 32'(gv_w[i]), 32'(ph == 1));
          chk("busy", i, 32'(busy_w[i]), 32'(ph != 0));
          chk("sym_count", i, 32'(cnt_w[i]), 32'(m_cnt[i]));
          chk("onehot_inv", i,
              32'(($countones(g_w[i]) <= 1) && (gv_w[i] == (g_w[i] != 4'b0))), 32'd1);
          if (gv_w[i] && !prev[i]) begin
            if (sb_size(i) == 0) begin
              chk("sb_unexpected", i, 32'd1, 32'd0);
            end else begin
              sb_pop(i, e);
              chk("sb_g", i, 32'(g_w[i]), 32'(e.g));
              chk("sb_count", i, 32'(cnt_w[i]), 32'(e.cnt));
            end
          end
          prev[i] = gv_w[i];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_el[i]     = 0;
      m_cnt[i]    = 0;
      m_g[i]      = 4'b0;
    end
    do_reset();

    // Basic decode of every code, one at a time.
    for (int c = 0; c < 4; c++) begin
      wait_idle(0);
      step(1'b1, 2'(c), 1'b0);
      step(1'b0, 2'd0, 1'b0);
    end
    wait_idle(0);
    wait_idle(1);
    wait_idle(2);
    step(1'b0, 2'd0, 1'b0);

    // Inputs toggling while busy must be ignored.
    step(1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'($urandom), 2'($urandom), 1'b0);
    wait_idle(0);
    wait_idle(2);

    // Back-to-back with in_valid held high.
    for (int k = 0; k < 5; k++) step(1'b1, 2'd3, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 2'd1, 1'b0);
    wait_idle(0);
    wait_idle(2);

    // Abort in the second drive cycle, then abort in idle with a valid code.
    step(1'b1, 2'd2, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd1, 1'b1);
    step(1'b0, 2'd0, 1'b0);

    // Asynchronous reset in the middle of driving code 2.
    step(1'b1, 2'd2, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    do_reset();

    // Five symbols into the 2-bit counter instance to force a wrap.
    for (int k = 0; k < 5; k++) begin
      wait_idle(2);
      step(1'b1, 2'($urandom), 1'b0);
    end
    wait_idle(2);

    // Random traffic with occasional aborts.
    for (int k = 0; k < 500; k++)
      step(1'($urandom), 2'($urandom), 1'(($urandom % 16) == 0));

    for (int k = 0; k < 12; k++) step(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < N; i++) chk("sb_leftover", i, 32'(sb_size(i)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
